// File: rtl/ntt_bridge_pkg.sv
// Shared definitions for the NTT stream bridge: controller state encoding,
// default geometry and the word-counter width helper.
package ntt_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_KICK   = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LANES  = 2;

    localparam int N     = 2 ** DEF_ADDR_W;
    localparam int WORDS = N / DEF_LANES;
    localparam int CNT_W = DEF_ADDR_W - $clog2(DEF_LANES) + 1;

    // Word counter must hold the full word count (one extra bit) so it never wraps.
    function automatic int cnt_width(input int addr_w, input int lanes);
        return addr_w - $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/ntt_skid_fifo.sv
// Two-entry valid/ready buffer for core read data. out_valid is a decode of
// the occupancy register only, so it never depends on pop in the same cycle.
module ntt_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   occ_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign pop_ok_s  = pop && (occ_r != 2'd0);
    assign push_ok_s = push && ((occ_r != 2'd2) || pop_ok_s);

    // Storage, pointers and occupancy; the writer never pushes into a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            occ_r <= occ_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

    assign out_valid = (occ_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign occupancy = occ_r;

endmodule

// File: rtl/ntt_stream_bridge.sv
// Streams one polynomial into the NTT core memory, kicks the core, waits for
// completion and streams the result back out through a 2-entry skid buffer.
// Optional feature macro: NTT_BRIDGE_STATS_EN adds stat_run_cycles.
module ntt_stream_bridge
    import ntt_bridge_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int LANES  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      core_we,
    output logic                      core_re,
    output logic [LANES*ADDR_W-1:0]   core_addr,
    output logic [LANES*DATA_W-1:0]   core_wdata,
    input  logic [LANES*DATA_W-1:0]   core_rdata,
    output logic                      core_start,
    output logic                      core_mode,
    input  logic                      core_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data
`ifdef NTT_BRIDGE_STATS_EN
    ,output logic [31:0]              stat_run_cycles
`endif
);

    localparam int WORDS_L = (2 ** ADDR_W) / LANES;
    localparam int CNT_L   = cnt_width(ADDR_W, LANES);
    localparam int WW      = LANES * DATA_W;
    localparam logic [CNT_L-1:0] LAST_IDX = CNT_L'(WORDS_L - 1);
    localparam logic [CNT_L-1:0] WORD_CNT = CNT_L'(WORDS_L);

    state_t                   state_r;
    state_t                   state_s;
    logic [CNT_L-1:0]         cnt_r;
    logic [CNT_L-1:0]         out_cnt_r;
    logic                     mode_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     in_ready_r;
    logic                     core_start_r;
    logic                     inflight_r;
    logic                     start_acc_s;
    logic                     we_s;
    logic                     re_s;
    logic                     done_s;
    logic                     pop_s;
    logic                     fifo_valid_s;
    logic [1:0]               occ_s;
    logic [2:0]               budget_s;
    logic [WW-1:0]            fifo_data_s;
    logic [LANES*ADDR_W-1:0]  core_addr_s;

    assign pop_s    = fifo_valid_s && out_ready;
    // Slots that will be taken after this edge if no new read is issued.
    assign budget_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};

    // Next-state and strobe decode for the job sequencer.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        we_s        = 1'b0;
        re_s        = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_acc_s = 1'b1;
                    state_s     = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    we_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        state_s = ST_KICK;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_KICK: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    state_s = ST_UNLOAD;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_UNLOAD: begin
                if ((cnt_r < WORD_CNT) && (budget_s < 3'd2)) begin
                    re_s = 1'b1;
                end else begin
                    re_s = 1'b0;
                end
                if (pop_s && (out_cnt_r == LAST_IDX)) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_UNLOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-lane core address, held at zero when no access is strobed.
    always_comb begin
        core_addr_s = {(LANES*ADDR_W){1'b0}};
        if (we_s || re_s) begin
            for (int l = 0; l < LANES; l++) begin
                core_addr_s[l*ADDR_W +: ADDR_W] = ADDR_W'(int'(cnt_r) * LANES + l);
            end
        end else begin
            core_addr_s = {(LANES*ADDR_W){1'b0}};
        end
    end

    // Sequencer state, counters and registered status/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_L{1'b0}};
            out_cnt_r    <= {CNT_L{1'b0}};
            mode_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            in_ready_r   <= 1'b0;
            core_start_r <= 1'b0;
            inflight_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= done_s;
            in_ready_r   <= (state_s == ST_LOAD);
            core_start_r <= (state_s == ST_KICK);
            inflight_r   <= re_s;
            if (start_acc_s) begin
                mode_r    <= mode;
                cnt_r     <= {CNT_L{1'b0}};
                out_cnt_r <= {CNT_L{1'b0}};
            end else if (we_s || re_s) begin
                cnt_r <= cnt_r + CNT_L'(1);
            end else if ((state_r == ST_RUN) && core_done) begin
                cnt_r <= {CNT_L{1'b0}};
            end
            if ((state_r == ST_UNLOAD) && pop_s) begin
                out_cnt_r <= out_cnt_r + CNT_L'(1);
            end
        end
    end

    ntt_skid_fifo #(
        .W (WW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (core_rdata),
        .pop       (pop_s),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_data_s),
        .occupancy (occ_s)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign in_ready   = in_ready_r;
    assign core_we    = we_s;
    assign core_re    = re_s;
    assign core_addr  = core_addr_s;
    assign core_wdata = we_s ? in_data : {WW{1'b0}};
    assign core_start = core_start_r;
    assign core_mode  = mode_r;
    assign out_valid  = fifo_valid_s;
    assign out_data   = fifo_data_s;

`ifdef NTT_BRIDGE_STATS_EN
    logic [31:0] run_cycles_r;

    // Saturating count of cycles spent waiting on the core for the latest job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_r <= 32'd0;
        end else if (start_acc_s) begin
            run_cycles_r <= 32'd0;
        end else if ((state_r == ST_RUN) && (run_cycles_r != 32'hFFFF_FFFF)) begin
            run_cycles_r <= run_cycles_r + 32'd1;
        end
    end

    assign stat_run_cycles = run_cycles_r;
`else
    // Statistics disabled: no run-cycle counter.
`endif

endmodule

// File: tb/tb_ntt_stream_bridge.sv
// Scoreboard bench for ntt_stream_bridge: default geometry instance plus a
// LANES=4/ADDR_W=4 instance. Build with NTT_BRIDGE_STATS_EN to check stats.
module tb_ntt_stream_bridge;

    localparam int LN = 2, WORDS = 128;
    localparam int BLN = 4, BWORDS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0, mode = 1'b0, busy, done;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_data = 32'd0;
    logic        core_we, core_re, core_start, core_mode, core_done;
    logic [15:0] core_addr;
    logic [31:0] core_wdata, core_rdata = 32'd0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data;
    logic        core_done_m = 1'b0, extra_done = 1'b0;
    assign core_done = core_done_m | extra_done;

    logic        b_start = 1'b0, b_mode = 1'b0, b_busy, b_done;
    logic        b_in_valid = 1'b0, b_in_ready;
    logic [63:0] b_in_data = 64'd0;
    logic        b_core_we, b_core_re, b_core_start, b_core_mode, b_core_done = 1'b0;
    logic [15:0] b_core_addr;
    logic [63:0] b_core_wdata, b_core_rdata = 64'd0;
    logic        b_out_valid, b_out_ready = 1'b0;
    logic [63:0] b_out_data;
`ifdef NTT_BRIDGE_STATS_EN
    logic [31:0] stat_run_cycles, b_stat_run_cycles;
`endif

    ntt_stream_bridge u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_we(core_we), .core_re(core_re), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_start(core_start), .core_mode(core_mode),
        .core_done(core_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef NTT_BRIDGE_STATS_EN
        , .stat_run_cycles(stat_run_cycles)
`endif
    );

    ntt_stream_bridge #(.DATA_W(16), .ADDR_W(4), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .busy(b_busy), .done(b_done),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .core_we(b_core_we), .core_re(b_core_re), .core_addr(b_core_addr),
        .core_wdata(b_core_wdata), .core_rdata(b_core_rdata), .core_start(b_core_start),
        .core_mode(b_core_mode), .core_done(b_core_done), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef NTT_BRIDGE_STATS_EN
        , .stat_run_cycles(b_stat_run_cycles)
`endif
    );

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- core models (environment) ----------------
    logic [15:0] cmem [256];
    logic [15:0] bmem [16];
    int run_len = 5, run_cnt = 0, brun = 0;
    bit running = 1'b0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        core_done_m <= 1'b0;
        if (!rst_n) begin
            running <= 1'b0;
        end else begin
            if (core_we) for (int l = 0; l < LN; l++) cmem[core_addr[l*8 +: 8]] <= core_wdata[l*16 +: 16];
            if (core_re) for (int l = 0; l < LN; l++) core_rdata[l*16 +: 16] <= cmem[core_addr[l*8 +: 8]] + 16'd1;
            if (core_start) begin
                running <= 1'b1;
                run_cnt <= run_len;
            end else if (running) begin
                if (run_cnt <= 1) begin
                    core_done_m <= 1'b1;
                    running <= 1'b0;
                end else run_cnt <= run_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        b_core_done <= 1'b0;
        if (!rst_n) begin
            brun <= 0;
        end else begin
            if (b_core_we) for (int l = 0; l < BLN; l++) bmem[b_core_addr[l*4 +: 4]] <= b_core_wdata[l*16 +: 16];
            if (b_core_re) for (int l = 0; l < BLN; l++) b_core_rdata[l*16 +: 16] <= bmem[b_core_addr[l*4 +: 4]] + 16'd1;
            if (b_core_start) brun <= 3;
            else if (brun > 0) begin
                if (brun == 1) b_core_done <= 1'b1;
                brun <= brun - 1;
            end
        end
    end

    // ---------------- scoreboard monitor, instance A ----------------
    logic [31:0] exp_q [$];
    int wr_idx = 0, rd_idx = 0, out_idx = 0, issued = 0, acc_cnt = 0, first_out = 0, last_out = 0;
    int kicks = 0;
    bit kick_next = 1'b0, done_next = 1'b0, job_mode = 1'b0;
    int ready_pct = 100;

    initial begin
        logic [31:0] w, e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                kick_next = 1'b0;
                done_next = 1'b0;
            end else begin
                check("core_start", core_start, kick_next);
                if (core_start) kicks++;
                check("done", done, done_next);
                if (done) check("busy_at_done", busy, 1'b0);
                if (busy) check("core_mode", core_mode, job_mode);
                kick_next = 1'b0;
                done_next = 1'b0;
                if (in_valid && in_ready) begin
                    check("wr_we", core_we, 1'b1);
                    for (int l = 0; l < LN; l++) check("wr_addr", core_addr[l*8 +: 8], 64'(wr_idx*LN + l));
                    check("wr_data", core_wdata, in_data);
                    for (int l = 0; l < LN; l++) w[l*16 +: 16] = in_data[l*16 +: 16] + 16'd1;
                    exp_q.push_back(w);
                    wr_idx++;
                    if (wr_idx == WORDS) kick_next = 1'b1;
                end else if (core_we) check("spurious_we", core_we, 1'b0);
                if (core_re) begin
                    for (int l = 0; l < LN; l++) check("rd_addr", core_addr[l*8 +: 8], 64'(rd_idx*LN + l));
                    rd_idx++;
                    issued++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("out_extra_word", 64'(out_idx), 64'(WORDS));
                    else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e);
                    end
                    if (out_idx == 0) first_out = cyc;
                    last_out = cyc;
                    out_idx++;
                    acc_cnt++;
                    if (out_idx == WORDS) done_next = 1'b1;
                end
                if (issued > 0) check("outstanding_le2", 64'((issued - acc_cnt) <= 2), 64'd1);
            end
        end
    end

    // random out_ready with the current duty cycle
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // ---------------- scoreboard monitor, instance B ----------------
    logic [63:0] bexp_q [$];
    int b_wr = 0, b_outs = 0, b_dones = 0;

    initial begin
        logic [63:0] w, e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (b_in_valid && b_in_ready) begin
                    for (int l = 0; l < BLN; l++) check("b_wr_addr", b_core_addr[l*4 +: 4], 64'(b_wr*BLN + l));
                    for (int l = 0; l < BLN; l++) w[l*16 +: 16] = b_in_data[l*16 +: 16] + 16'd1;
                    bexp_q.push_back(w);
                    b_wr++;
                end
                if (b_out_valid && b_out_ready) begin
                    if (bexp_q.size() == 0) check("b_out_extra", 64'(b_outs), 64'(BWORDS));
                    else begin
                        e = bexp_q.pop_front();
                        check("b_out_data", b_out_data, e);
                    end
                    b_outs++;
                end
                if (b_done) b_dones++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_core_we"}, core_we, 1'b0);
        check({tag, "_core_re"}, core_re, 1'b0);
        check({tag, "_core_start"}, core_start, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_core_addr"}, core_addr, 16'd0);
        check({tag, "_core_wdata"}, core_wdata, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_core_mode"}, core_mode, 1'b0);
    endtask

    // One job on instance A; rst_at > 0 aborts with reset after that many outputs.
    task automatic do_job(input bit m, input int in_pct, input int out_pct, input int rlen,
                          input bit glitch, input int rst_at);
        int sent, guard;
        bit seen_done;
        wr_idx = 0; rd_idx = 0; out_idx = 0; issued = 0; acc_cnt = 0; kicks = 0;
        exp_q.delete();
        job_mode = m; run_len = rlen; ready_pct = out_pct;
        @(posedge clk); #1; start = 1'b1; mode = m;
        @(posedge clk); #1; start = 1'b0; mode = ~m;
        sent = 0; guard = 0;
        while (sent < WORDS && guard < 20000) begin
            in_valid   = ($urandom_range(99) < in_pct);
            in_data    = $urandom;
            start      = glitch && (sent == 50);
            extra_done = glitch && (sent == 60);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0; start = 1'b0; extra_done = 1'b0;
        if (sent < WORDS) check("load_timeout", 64'(sent), 64'(WORDS));
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
        end
        seen_done = 1'b0; guard = 0;
        while (!seen_done && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (rst_at > 0 && out_idx >= rst_at) begin
                @(posedge clk); #1; rst_n = 1'b0;
                @(negedge clk);
                check_reset_outputs("midjob_rst");
                @(posedge clk); #1; rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            seen_done = done;
        end
        if (!seen_done) check("done_timeout", 64'(out_idx), 64'(WORDS));
        check("job_outputs", 64'(out_idx), 64'(WORDS));
        check("job_kicks", 64'(kicks), 64'd1);
        check("job_queue_empty", 64'(exp_q.size()), 64'd0);
        if (out_pct == 100) check("throughput_span", 64'(last_out - first_out), 64'(WORDS - 1));
    endtask

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
`ifdef NTT_BRIDGE_STATS_EN
        check("reset_stat", stat_run_cycles, 32'd0);
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_job(1'b0, 100, 100, 8, 1'b0, 0);    // full-rate load and unload
        do_job(1'b0, 70, 30, 12, 1'b0, 0);     // 30% out_ready duty
        do_job(1'b1, 80, 60, 15, 1'b1, 0);     // start/core_done glitches, inverse mode
        do_job(1'b0, 100, 100, 6, 1'b0, 40);   // reset during unload
        do_job(1'b1, 100, 100, 36, 1'b0, 0);   // clean job after reset, 37 RUN cycles
`ifdef NTT_BRIDGE_STATS_EN
        check("stat_run_cycles", stat_run_cycles, 32'd37);
`endif

        // instance B: LANES=4, ADDR_W=4
        b_out_ready = 1'b1;
        @(posedge clk); #1; b_start = 1'b1;
        @(posedge clk); #1; b_start = 1'b0;
        guard = 0;
        while (b_wr < BWORDS && guard < 200) begin
            b_in_valid = 1'b1;
            b_in_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            guard++;
        end
        b_in_valid = 1'b0;
        guard = 0;
        while (b_dones == 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        @(negedge clk);
        check("b_writes", 64'(b_wr), 64'(BWORDS));
        check("b_outputs", 64'(b_outs), 64'(BWORDS));
        check("b_done_pulses", 64'(b_dones), 64'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
